// File: rtl/security_alert_sequencer.sv
// Alert dispatch controller: entry delay for intrusions, ordered app/email/SMS
// notifications over req/ack with timeout and retry, latched alarm and re-arm hold-off.
module security_alert_sequencer #(
  parameter int ENTRY_DELAY = 8,
  parameter int ACK_TIMEOUT = 16,
  parameter int MAX_RETRIES = 2,
  parameter int HOLDOFF     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       armed,
  input  logic       intruder_detected,
  input  logic       system_compromised,
  input  logic       user_clear,
  output logic       app_req,
  input  logic       app_ack,
  output logic       email_req,
  input  logic       email_ack,
  output logic       sms_req,
  input  logic       sms_ack,
  output logic       alarm_active,
  output logic [1:0] cause,
  output logic [2:0] fail_flags
);

  localparam int MAX_AB = (ENTRY_DELAY > ACK_TIMEOUT) ? ENTRY_DELAY : ACK_TIMEOUT;
  localparam int MAX_T  = (MAX_AB > HOLDOFF) ? MAX_AB : HOLDOFF;
  localparam int TW     = $clog2(MAX_T + 1);
  localparam int RW     = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [TW-1:0] ENTRY_LOAD = TW'(ENTRY_DELAY - 1);
  localparam logic [TW-1:0] ACK_LOAD   = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLDOFF - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_DISP_APP, S_DISP_EMAIL, S_DISP_SMS, S_GAP, S_LATCHED, S_HOLDOFF
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      chan_q, chan_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [1:0]      cause_q, cause_d;
  logic [2:0]      fail_q, fail_d;
  logic            app_req_q, email_req_q, sms_req_q, alarm_q;
  logic            app_req_d, email_req_d, sms_req_d, alarm_d;

  logic            start, adv, ack_sel;
  logic [1:0]      start_cause, live_cause;

  function automatic state_e disp_of(input logic [1:0] ch);
    case (ch)
      2'd0:    return S_DISP_APP;
      2'd1:    return S_DISP_EMAIL;
      default: return S_DISP_SMS;
    endcase
  endfunction

  assign live_cause = {system_compromised, armed & intruder_detected};

  always_comb begin
    case (chan_q)
      2'd0:    ack_sel = app_ack;
      2'd1:    ack_sel = email_ack;
      default: ack_sel = sms_ack;
    endcase
  end

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    timer_d     = (timer_q != '0) ? timer_q - 1'b1 : '0;
    retry_d     = retry_q;
    cause_d     = cause_q;
    fail_d      = fail_q;
    start       = 1'b0;
    adv         = 1'b0;
    start_cause = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (system_compromised) begin
          start       = 1'b1;
          start_cause = {1'b1, armed & intruder_detected};
        end else if (armed && intruder_detected) begin
          state_d = S_ENTRY;
          timer_d = ENTRY_LOAD;
        end
      end
      S_ENTRY: begin
        // A compromise during the entry delay dispatches at once, armed or not.
        if (system_compromised) begin
          start       = 1'b1;
          start_cause = {1'b1, armed & intruder_detected};
        end else if (!armed) begin
          state_d = S_IDLE;
        end else if (timer_q == '0) begin
          start       = 1'b1;
          start_cause = 2'b01;
        end
      end
      S_DISP_APP, S_DISP_EMAIL, S_DISP_SMS: begin
        cause_d = cause_q | live_cause;
        if (ack_sel)                adv     = 1'b1;
        else if (timer_q == '0)     state_d = S_GAP;
      end
      S_GAP: begin
        cause_d = cause_q | live_cause;
        if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 1'b1;
          state_d = disp_of(chan_q);
          timer_d = ACK_LOAD;
        end else begin
          fail_d[chan_q] = 1'b1;
          adv            = 1'b1;
        end
      end
      S_LATCHED: begin
        cause_d = cause_q | live_cause;
        if (user_clear) begin
          state_d = S_HOLDOFF;
          cause_d = 2'b00;
          timer_d = HOLD_LOAD;
        end
      end
      S_HOLDOFF: begin
        if (timer_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      state_d = S_DISP_APP;
      chan_d  = 2'd0;
      retry_d = '0;
      timer_d = ACK_LOAD;
      cause_d = start_cause;
      fail_d  = 3'b000;
    end

    if (adv) begin
      retry_d = '0;
      timer_d = ACK_LOAD;
      if (chan_q == 2'd2) begin
        state_d = S_LATCHED;
      end else begin
        chan_d  = chan_q + 2'd1;
        state_d = disp_of(chan_q + 2'd1);
      end
    end
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_comb begin
    app_req_d   = (state_d == S_DISP_APP);
    email_req_d = (state_d == S_DISP_EMAIL);
    sms_req_d   = (state_d == S_DISP_SMS);
    alarm_d     = (state_d == S_DISP_APP) || (state_d == S_DISP_EMAIL) ||
                  (state_d == S_DISP_SMS) || (state_d == S_GAP) || (state_d == S_LATCHED);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      chan_q      <= 2'd0;
      timer_q     <= '0;
      retry_q     <= '0;
      cause_q     <= 2'b00;
      fail_q      <= 3'b000;
      app_req_q   <= 1'b0;
      email_req_q <= 1'b0;
      sms_req_q   <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      cause_q     <= cause_d;
      fail_q      <= fail_d;
      app_req_q   <= app_req_d;
      email_req_q <= email_req_d;
      sms_req_q   <= sms_req_d;
      alarm_q     <= alarm_d;
    end
  end

  assign app_req      = app_req_q;
  assign email_req    = email_req_q;
  assign sms_req      = sms_req_q;
  assign alarm_active = alarm_q;
  assign cause        = cause_q;
  assign fail_flags   = fail_q;

endmodule

// File: tb/tb_security_alert_sequencer.sv
// Self-checking bench: req rising edges are scoreboarded against expected (channel, cycle)
// entries queued when stimulus is applied; level outputs are checked at chosen cycles.
module tb_security_alert_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       armed, intruder_detected, system_compromised, user_clear;
  logic       app_req, app_ack, email_req, email_ack, sms_req, sms_ack;
  logic       alarm_active;
  logic [1:0] cause;
  logic [2:0] fail_flags;

  security_alert_sequencer dut (
    .clk                (clk),
    .rst                (rst),
    .armed              (armed),
    .intruder_detected  (intruder_detected),
    .system_compromised (system_compromised),
    .user_clear         (user_clear),
    .app_req            (app_req),
    .app_ack            (app_ack),
    .email_req          (email_req),
    .email_ack          (email_ack),
    .sms_req            (sms_req),
    .sms_ack            (sms_ack),
    .alarm_active       (alarm_active),
    .cause              (cause),
    .fail_flags         (fail_flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    string tag;
    int    chan;
    int    at;
  } exp_t;

  exp_t exp_q[$];

  task automatic expect_req(input string tag, input int ch, input int at);
    exp_t e;
    e.tag = tag; e.chan = ch; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Channel responders: ack one cycle after seeing req, when enabled.
  logic [2:0] ack_en;
  always @(negedge clk) begin
    app_ack   = app_req   & ack_en[0];
    email_ack = email_req & ack_en[1];
    sms_ack   = sms_req   & ack_en[2];
  end

  // Scoreboard: every req rising edge must match the head of the expected queue.
  logic [2:0] prev_req = 3'b000;
  always @(negedge clk) begin
    logic [2:0] cur;
    exp_t e;
    cur = {sms_req, email_req, app_req};
    for (int ch = 0; ch < 3; ch++) begin
      if (cur[ch] && !prev_req[ch]) begin
        if (exp_q.size() == 0) begin
          check("spurious_req", ch, 32'hff);
        end else begin
          e = exp_q.pop_front();
          check({e.tag, "_chan"}, ch, e.chan);
          check({e.tag, "_cycle"}, cyc, e.at);
        end
      end
    end
    prev_req = cur;
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_reqs"},  {sms_req, email_req, app_req}, 3'b000);
    check({tag, "_alarm"}, alarm_active, 1'b0);
    check({tag, "_cause"}, cause, 2'b00);
    check({tag, "_fail"},  fail_flags, 3'b000);
  endtask

  initial begin
    int c, d;
    rst = 1'b1;
    armed = 1'b0; intruder_detected = 1'b0; system_compromised = 1'b0; user_clear = 1'b0;
    app_ack = 1'b0; email_ack = 1'b0; sms_ack = 1'b0;
    ack_en = 3'b111;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Armed intrusion, all acks prompt.
    c = cyc;
    expect_req("t1_app", 0, c + 9);
    expect_req("t1_email", 1, c + 10);
    expect_req("t1_sms", 2, c + 11);
    armed = 1'b1; intruder_detected = 1'b1;
    wait_until(c + 8);
    check("t1_app_before_delay", app_req, 1'b0);
    check("t1_alarm_before_delay", alarm_active, 1'b0);
    wait_until(c + 9);
    check("t1_alarm_at_dispatch", alarm_active, 1'b1);
    wait_until(c + 12);
    check("t1_latched_alarm", alarm_active, 1'b1);
    check("t1_latched_cause", cause, 2'b01);
    check("t1_latched_fail", fail_flags, 3'b000);
    check("t1_latched_reqs", {sms_req, email_req, app_req}, 3'b000);

    // User clear with intrusion held: hold-off, then fresh entry delay and dispatch.
    d = cyc;
    user_clear = 1'b1;
    @(negedge clk);
    user_clear = 1'b0;
    check("t5_alarm_cleared", alarm_active, 1'b0);
    check("t5_cause_cleared", cause, 2'b00);
    ack_en = 3'b011;
    expect_req("t5_app", 0, d + 14);
    expect_req("t5_email", 1, d + 15);
    expect_req("t5_sms", 2, d + 16);
    wait_until(d + 13);
    check("t5_alarm_in_entry", alarm_active, 1'b0);
    wait_until(d + 14);
    check("t5_alarm_redispatch", alarm_active, 1'b1);
    check("t5_cause_redispatch", cause, 2'b01);

    // Asynchronous reset while sms_req is high.
    wait_until(d + 17);
    check("t6_sms_high", sms_req, 1'b1);
    #2 rst = 1'b1;
    #1 check_idle_outputs("t6_async_reset");
    armed = 1'b0; intruder_detected = 1'b0; ack_en = 3'b111;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_idle_outputs("t6_after_release");

    // Disarm during entry delay: nothing dispatched.
    c = cyc;
    armed = 1'b1; intruder_detected = 1'b1;
    wait_until(c + 5);
    armed = 1'b0;
    wait_until(c + 14);
    check("t2_alarm", alarm_active, 1'b0);
    check("t2_cause", cause, 2'b00);
    intruder_detected = 1'b0;
    repeat (2) @(negedge clk);

    // Unarmed compromise pulse; unarmed intrusion ignored, armed intrusion accumulates.
    c = cyc;
    expect_req("t3_app", 0, c + 1);
    expect_req("t3_email", 1, c + 2);
    expect_req("t3_sms", 2, c + 3);
    system_compromised = 1'b1;
    @(negedge clk);
    system_compromised = 1'b0;
    check("t3_cause_start", cause, 2'b10);
    intruder_detected = 1'b1;
    wait_until(c + 4);
    check("t3_cause_unarmed", cause, 2'b10);
    check("t3_alarm_latched", alarm_active, 1'b1);
    armed = 1'b1;
    @(negedge clk);
    check("t3_cause_armed", cause, 2'b11);
    armed = 1'b0; intruder_detected = 1'b0;
    user_clear = 1'b1;
    @(negedge clk);
    user_clear = 1'b0;
    repeat (8) @(negedge clk);

    // Email never acks: three 16-cycle attempts with 1-cycle gaps, then failure and SMS.
    ack_en = 3'b101;
    c = cyc;
    expect_req("t4_app", 0, c + 1);
    expect_req("t4_email_try0", 1, c + 2);
    expect_req("t4_email_try1", 1, c + 19);
    expect_req("t4_email_try2", 1, c + 36);
    expect_req("t4_sms", 2, c + 53);
    system_compromised = 1'b1;
    @(negedge clk);
    system_compromised = 1'b0;
    wait_until(c + 17);
    check("t4_email_last_high", email_req, 1'b1);
    wait_until(c + 18);
    check("t4_email_gap", email_req, 1'b0);
    check("t4_alarm_gap", alarm_active, 1'b1);
    wait_until(c + 52);
    check("t4_fail_before", fail_flags, 3'b000);
    wait_until(c + 53);
    check("t4_fail_email", fail_flags, 3'b010);
    wait_until(c + 55);
    check("t4_latched_cause", cause, 2'b10);
    check("t4_latched_fail", fail_flags, 3'b010);
    user_clear = 1'b1;
    @(negedge clk);
    user_clear = 1'b0;
    check("t4_fail_held", fail_flags, 3'b010);
    check("t4_alarm_off", alarm_active, 1'b0);
    repeat (8) @(negedge clk);

    check("pending_expectations", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
